// File: rtl/motion_zone_pkg.sv
// Shared types and constants for the per-zone motion bounding-box stage.
package motion_zone_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_ACTIVE,
    ST_EVAL,
    ST_PUBLISH
  } state_e;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_ZONES      = 4;
  localparam int DEF_COORD_W    = 11;
  localparam int DEF_MIN_PIXELS = 1000;
  localparam int DEF_PERSIST    = 2;

  // Smallest n with 2**n >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int w, input int h);
    return clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/motion_zone_box_if.sv
// Binary motion-mask pixel stream with frame/line framing.
interface motion_zone_box_if;
  logic pre_img_vsync;
  logic pre_img_hsync;
  logic pre_img_valid;
  logic pre_img_data;

  modport master (output pre_img_vsync, output pre_img_hsync,
                  output pre_img_valid, output pre_img_data);
  modport slave  (input pre_img_vsync, input pre_img_hsync,
                  input pre_img_valid, input pre_img_data);
endinterface

// File: rtl/zone_box_acc.sv
// One zone: bounding box, saturating pixel count and persistence counter.
module zone_box_acc
  import motion_zone_pkg::*;
#(
  parameter int COORD_W    = DEF_COORD_W,
  parameter int CNT_W      = cnt_w(DEF_IMG_WIDTH, DEF_IMG_HEIGHT),
  parameter int MIN_PIXELS = DEF_MIN_PIXELS,
  parameter int PERSIST    = DEF_PERSIST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               hit,
  input  logic               eval,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] min_x,
  output logic [COORD_W-1:0] max_x,
  output logic [COORD_W-1:0] min_y,
  output logic [COORD_W-1:0] max_y,
  output logic               qualified,
  output logic               box_flag
);
  localparam int PW = 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_PIXELS);
  localparam logic [PW-1:0]    PERSIST_L = PW'(PERSIST);

  logic               any_q, any_d;
  logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PW-1:0]      persist_q, persist_d;

  assign qualified = (count_q >= MIN_CNT);
  assign box_flag  = (persist_q == PERSIST_L);
  assign min_x = min_x_q;
  assign max_x = max_x_q;
  assign min_y = min_y_q;
  assign max_y = max_y_q;

  always_comb begin
    any_d     = any_q;
    min_x_d   = min_x_q;
    max_x_d   = max_x_q;
    min_y_d   = min_y_q;
    max_y_d   = max_y_q;
    count_d   = count_q;
    persist_d = persist_q;
    if (clear) begin
      any_d   = 1'b0;
      min_x_d = '0;
      max_x_d = '0;
      min_y_d = '0;
      max_y_d = '0;
      count_d = '0;
    end else if (hit) begin
      // The first hit of a frame seeds the box instead of comparing to stale bounds.
      any_d = 1'b1;
      if (!any_q || x < min_x_q) min_x_d = x;
      if (!any_q || x > max_x_q) max_x_d = x;
      if (!any_q || y < min_y_q) min_y_d = y;
      if (!any_q || y > max_y_q) max_y_d = y;
      if (count_q != CNT_MAX) count_d = count_q + 1'b1;
    end
    if (eval) begin
      if (!qualified)                persist_d = '0;
      else if (persist_q != PERSIST_L) persist_d = persist_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_q     <= 1'b0;
      min_x_q   <= '0;
      max_x_q   <= '0;
      min_y_q   <= '0;
      max_y_q   <= '0;
      count_q   <= '0;
      persist_q <= '0;
    end else begin
      any_q     <= any_d;
      min_x_q   <= min_x_d;
      max_x_q   <= max_x_d;
      min_y_q   <= min_y_d;
      max_y_q   <= max_y_d;
      count_q   <= count_d;
      persist_q <= persist_d;
    end
  end
endmodule

// File: rtl/motion_zone_box.sv
// Splits the motion mask into vertical strips and publishes a filtered box per strip at frame end.
module motion_zone_box
  import motion_zone_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ZONES      = DEF_ZONES,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int MIN_PIXELS = DEF_MIN_PIXELS,
  parameter int PERSIST    = DEF_PERSIST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  motion_zone_box_if.slave         pix,
  output logic [ZONES-1:0]         box_flag,
  output logic [ZONES*COORD_W-1:0] top_edge,
  output logic [ZONES*COORD_W-1:0] bottom_edge,
  output logic [ZONES*COORD_W-1:0] left_edge,
  output logic [ZONES*COORD_W-1:0] right_edge,
  output logic                     frame_done
);
  localparam int ZONE_W = IMG_WIDTH / ZONES;
  localparam int CNT_W  = cnt_w(IMG_WIDTH, IMG_HEIGHT);
  localparam int ZI_W   = clog2(ZONES + 1);
  localparam logic [COORD_W-1:0] X_LIM   = COORD_W'(IMG_WIDTH);
  localparam logic [COORD_W-1:0] Y_LIM   = COORD_W'(IMG_HEIGHT);
  localparam logic [COORD_W-1:0] XZ_LAST = COORD_W'(ZONE_W - 1);

  state_e state_q, state_d;
  logic   vsync_q, hsync_q, line_px_q, line_px_d;
  logic   [COORD_W-1:0] x_q, x_d, xz_q, xz_d, y_q, y_d;
  logic   [ZI_W-1:0]    zone_q, zone_d;
  logic   vs_rise, vs_fall, hs_fall, clear, eval, publish, hit_any;

  logic [ZONES-1:0]         qual, zflag, box_flag_q, box_flag_d;
  logic [COORD_W-1:0]       min_x [ZONES];
  logic [COORD_W-1:0]       max_x [ZONES];
  logic [COORD_W-1:0]       min_y [ZONES];
  logic [COORD_W-1:0]       max_y [ZONES];
  logic [ZONES*COORD_W-1:0] top_q, top_d, bot_q, bot_d, left_q, left_d, right_q, right_d;
  logic                     frame_done_q, frame_done_d;

  assign vs_rise = pix.pre_img_vsync & ~vsync_q;
  assign vs_fall = ~pix.pre_img_vsync & vsync_q;
  assign hs_fall = ~pix.pre_img_hsync & hsync_q;
  assign clear   = (state_q == ST_IDLE) & vs_rise;
  assign hit_any = (state_q == ST_ACTIVE) & pix.pre_img_vsync & pix.pre_img_valid &
                   pix.pre_img_data & (x_q < X_LIM) & (y_q < Y_LIM);

  always_comb begin
    state_d = state_q;
    eval    = 1'b0;
    publish = 1'b0;
    unique case (state_q)
      ST_SYNC:    if (!pix.pre_img_vsync) state_d = ST_IDLE;
      ST_IDLE:    if (vs_rise) state_d = ST_ACTIVE;
      ST_ACTIVE:  if (vs_fall) state_d = ST_EVAL;
      ST_EVAL:    begin eval = 1'b1; state_d = ST_PUBLISH; end
      ST_PUBLISH: begin publish = 1'b1; state_d = ST_IDLE; end
      default:    state_d = ST_SYNC;
    endcase
  end

  // Zone index follows x via a within-strip offset, so no divider is needed.
  always_comb begin
    x_d       = x_q;
    xz_d      = xz_q;
    zone_d    = zone_q;
    y_d       = y_q;
    line_px_d = line_px_q;
    if (clear) begin
      x_d       = '0;
      xz_d      = '0;
      zone_d    = '0;
      y_d       = '0;
      line_px_d = 1'b0;
    end else begin
      if (pix.pre_img_valid) begin
        line_px_d = 1'b1;
        if (x_q < X_LIM) begin
          x_d = x_q + 1'b1;
          if (xz_q == XZ_LAST) begin
            xz_d   = '0;
            zone_d = zone_q + 1'b1;
          end else begin
            xz_d = xz_q + 1'b1;
          end
        end
      end
      if (hs_fall) begin
        x_d       = '0;
        xz_d      = '0;
        zone_d    = '0;
        line_px_d = 1'b0;
        if ((line_px_q || pix.pre_img_valid) && y_q < Y_LIM) y_d = y_q + 1'b1;
      end
    end
  end

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    zone_box_acc #(
      .COORD_W(COORD_W), .CNT_W(CNT_W), .MIN_PIXELS(MIN_PIXELS), .PERSIST(PERSIST)
    ) u_acc (
      .clk, .rst_n, .clear, .eval,
      .hit      (hit_any && (zone_q == ZI_W'(z))),
      .x        (x_q),
      .y        (y_q),
      .min_x    (min_x[z]),
      .max_x    (max_x[z]),
      .min_y    (min_y[z]),
      .max_y    (max_y[z]),
      .qualified(qual[z]),
      .box_flag (zflag[z])
    );
  end

  // Non-qualifying zones keep their last published edges.
  always_comb begin
    box_flag_d   = box_flag_q;
    top_d        = top_q;
    bot_d        = bot_q;
    left_d       = left_q;
    right_d      = right_q;
    frame_done_d = publish;
    if (publish) begin
      box_flag_d = zflag;
      for (int z = 0; z < ZONES; z++) begin
        if (qual[z]) begin
          top_d[z*COORD_W +: COORD_W]   = min_y[z];
          bot_d[z*COORD_W +: COORD_W]   = max_y[z];
          left_d[z*COORD_W +: COORD_W]  = min_x[z];
          right_d[z*COORD_W +: COORD_W] = max_x[z];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SYNC;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      line_px_q    <= 1'b0;
      x_q          <= '0;
      xz_q         <= '0;
      zone_q       <= '0;
      y_q          <= '0;
      box_flag_q   <= '0;
      top_q        <= '0;
      bot_q        <= '0;
      left_q       <= '0;
      right_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= pix.pre_img_vsync;
      hsync_q      <= pix.pre_img_hsync;
      line_px_q    <= line_px_d;
      x_q          <= x_d;
      xz_q         <= xz_d;
      zone_q       <= zone_d;
      y_q          <= y_d;
      box_flag_q   <= box_flag_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      left_q       <= left_d;
      right_q      <= right_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign box_flag    = box_flag_q;
  assign top_edge    = top_q;
  assign bottom_edge = bot_q;
  assign left_edge   = left_q;
  assign right_edge  = right_q;
  assign frame_done  = frame_done_q;
endmodule

// File: tb/tb_motion_zone_box.sv
// Directed bench for motion_zone_box on a 64x32 frame split into four 16-pixel strips.
module tb_motion_zone_box;
  localparam int W  = 64;
  localparam int H  = 32;
  localparam int Z  = 4;
  localparam int CW = 11;

  logic clk;
  logic rst_n;
  logic [Z-1:0]    box_flag;
  logic [Z*CW-1:0] top_edge, bottom_edge, left_edge, right_edge;
  logic            frame_done;

  int n_cmp;
  int n_fail;
  bit mask [H][70];

  motion_zone_box_if pix ();

  motion_zone_box #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .ZONES(Z), .COORD_W(CW), .MIN_PIXELS(4), .PERSIST(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (pix),
    .box_flag   (box_flag),
    .top_edge   (top_edge),
    .bottom_edge(bottom_edge),
    .left_edge  (left_edge),
    .right_edge (right_edge),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] fld(input logic [Z*CW-1:0] v, input int z);
    return v[z*CW +: CW];
  endfunction

  task automatic check_zone(input string tag, input int z, input int l, input int r,
                            input int t, input int b);
    check({tag, "_left"},   64'(fld(left_edge, z)),   64'(l));
    check({tag, "_right"},  64'(fld(right_edge, z)),  64'(r));
    check({tag, "_top"},    64'(fld(top_edge, z)),    64'(t));
    check({tag, "_bottom"}, 64'(fld(bottom_edge, z)), 64'(b));
  endtask

  task automatic clear_mask();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < 70; x++) mask[y][x] = 1'b0;
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) mask[y][x] = 1'b1;
  endtask

  task automatic send_line(input int y, input int npix);
    pix.pre_img_hsync = 1'b1;
    tick();
    for (int x = 0; x < npix; x++) begin
      pix.pre_img_valid = 1'b1;
      pix.pre_img_data  = mask[y][x];
      tick();
    end
    pix.pre_img_valid = 1'b0;
    pix.pre_img_data  = 1'b0;
    pix.pre_img_hsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_frame();
    pix.pre_img_vsync = 1'b1;
    tick();
    tick();
  endtask

  // vsync is sampled low on the first tick; frame_done must follow two ticks later.
  task automatic end_frame(input string tag, input bit rerise);
    pix.pre_img_vsync = 1'b0;
    tick();
    check({tag, "_done_t0"}, 64'(frame_done), 64'd0);
    pix.pre_img_hsync = 1'b0;
    if (rerise) pix.pre_img_vsync = 1'b1;
    tick();
    check({tag, "_done_t1"}, 64'(frame_done), 64'd0);
    tick();
    check({tag, "_done_t2"}, 64'(frame_done), 64'd1);
  endtask

  task automatic full_frame(input string tag, input int npix);
    start_frame();
    for (int y = 0; y < H; y++) send_line(y, npix);
    end_frame(tag, 1'b0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    pix.pre_img_vsync = 1'b1;
    pix.pre_img_hsync = 1'b0;
    pix.pre_img_valid = 1'b0;
    pix.pre_img_data  = 1'b0;
    clear_mask();
    tick();
    tick();
    check("rst_flag",  64'(box_flag),    64'd0);
    check("rst_left",  64'(left_edge),   64'd0);
    check("rst_right", 64'(right_edge),  64'd0);
    check("rst_top",   64'(top_edge),    64'd0);
    check("rst_bot",   64'(bottom_edge), 64'd0);
    check("rst_done",  64'(frame_done),  64'd0);

    // Partial frame after reset release: must not publish.
    rst_n = 1'b1;
    set_rect(20, 23, 5, 6);
    for (int y = 0; y < 8; y++) send_line(y, W);
    pix.pre_img_vsync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("partial_no_done", 64'(frame_done), 64'd0);
    end
    check("partial_flag", 64'(box_flag), 64'd0);
    check("partial_left", 64'(left_edge), 64'd0);

    clear_mask();
    full_frame("empty", W);
    check("empty_flag",  64'(box_flag),  64'd0);
    check("empty_left",  64'(left_edge), 64'd0);
    check("empty_top",   64'(top_edge),  64'd0);
    tick();
    check("done_one_cycle", 64'(frame_done), 64'd0);

    set_rect(20, 23, 5, 6);
    full_frame("blob1", W);
    check("blob1_flag", 64'(box_flag), 64'b0000);
    check_zone("blob1_z1", 1, 20, 23, 5, 6);
    full_frame("blob2", W);
    check("blob2_flag", 64'(box_flag), 64'b0010);
    check_zone("blob2_z1", 1, 20, 23, 5, 6);
    check_zone("blob2_z0", 0, 0, 0, 0, 0);

    clear_mask();
    set_rect(20, 22, 5, 5);
    full_frame("small", W);
    check("small_flag", 64'(box_flag), 64'b0000);
    check_zone("small_z1_hold", 1, 20, 23, 5, 6);

    clear_mask();
    set_rect(14, 17, 10, 13);
    full_frame("span1", W);
    check("span1_flag", 64'(box_flag), 64'b0000);
    full_frame("span2", W);
    check("span2_flag", 64'(box_flag), 64'b0011);
    check_zone("span2_z0", 0, 14, 15, 10, 13);
    check_zone("span2_z1", 1, 16, 17, 10, 13);

    clear_mask();
    set_rect(64, 69, 0, H - 1);
    full_frame("oor", 70);
    check("oor_flag", 64'(box_flag), 64'b0000);
    check_zone("oor_z0_hold", 0, 14, 15, 10, 13);
    check_zone("oor_z1_hold", 1, 16, 17, 10, 13);

    // vsync falls mid-line 31 right after pixel x=29, then rises again during EVAL.
    clear_mask();
    set_rect(25, 29, 31, 31);
    start_frame();
    for (int y = 0; y < H - 1; y++) send_line(y, W);
    pix.pre_img_hsync = 1'b1;
    tick();
    for (int x = 0; x < 30; x++) begin
      pix.pre_img_valid = 1'b1;
      pix.pre_img_data  = mask[H-1][x];
      tick();
    end
    pix.pre_img_valid = 1'b0;
    pix.pre_img_data  = 1'b0;
    end_frame("midline", 1'b1);
    check("midline_flag", 64'(box_flag), 64'b0000);
    check_zone("midline_z1", 1, 25, 29, 31, 31);
    check_zone("midline_z0_hold", 0, 14, 15, 10, 13);

    // The frame whose vsync rose during EVAL carries a zone-2 blob and must be missed.
    clear_mask();
    set_rect(40, 43, 5, 6);
    for (int y = 0; y < H; y++) send_line(y, W);
    pix.pre_img_vsync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("missed_no_done", 64'(frame_done), 64'd0);
    end
    check_zone("missed_z2", 2, 0, 0, 0, 0);

    full_frame("z2a", W);
    check("z2a_flag", 64'(box_flag), 64'b0000);
    check_zone("z2a_z2", 2, 40, 43, 5, 6);
    check_zone("z2a_z1_hold", 1, 25, 29, 31, 31);
    full_frame("z2b", W);
    check("z2b_flag", 64'(box_flag), 64'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
